// File: rtl/eth_phy_prbs31_test_ctrl.sv
// ---------------------------------------------------------------------------
// eth_phy_prbs31_test_ctrl
//
// PRBS31 link self-test sequencer for the 10G Ethernet PHY. A start request
// enables the PHY TX PRBS31 generator and RX PRBS31 checker, pulses the PHY
// receive reset, waits for block lock, discards a settle period and then
// accumulates rx_error_count over a programmed window. The controller
// reports a saturating error total and a pass/fail verdict against an
// inclusive threshold.
//
// Ports:
//   rx_clk, rx_rst_n      sole clock (PHY rx/tx domain), async active-low reset
//   start, abort          test request (IDLE only) / cancel (any non-IDLE state)
//   cfg_window_len        measurement window in cycles (latched at start)
//   cfg_err_threshold     max errors for pass, inclusive (latched at start)
//   cfg_lock_timeout      max WAIT_LOCK cycles (latched at start)
//   rx_block_lock, rx_high_ber, rx_error_count   status from the PHY
//   cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, phy_rx_rst   controls to PHY
//   busy, done, pass, fail_code, high_ber_seen, err_total    test status
// ---------------------------------------------------------------------------
module eth_phy_prbs31_test_ctrl #(
  parameter int ERR_CNT_WIDTH = 7,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              cfg_window_len,
  input  logic [31:0]              cfg_err_threshold,
  input  logic [15:0]              cfg_lock_timeout,
  input  logic                     rx_block_lock,
  input  logic                     rx_high_ber,
  input  logic [ERR_CNT_WIDTH-1:0] rx_error_count,
  output logic                     cfg_tx_prbs31_enable,
  output logic                     cfg_rx_prbs31_enable,
  output logic                     phy_rx_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic                     high_ber_seen,
  output logic [31:0]              err_total
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENABLE    = 3'd1,
    S_RX_RESET  = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_SETTLE    = 3'd4,
    S_MEASURE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [1:0]  FC_NONE     = 2'd0;
  localparam logic [1:0]  FC_TIMEOUT  = 2'd1;
  localparam logic [1:0]  FC_LOCKLOST = 2'd2;
  localparam logic [1:0]  FC_THRESH   = 2'd3;
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  // One phase counter is shared by RX_RESET, WAIT_LOCK, SETTLE and MEASURE;
  // it is cleared on every entry into a counted state.
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] window_q, window_d;
  logic [31:0] thr_q, thr_d;
  logic [15:0] tout_q, tout_d;
  logic [31:0] err_q, err_d;
  logic        pass_q, pass_d;
  logic [1:0]  fail_q, fail_d;
  logic        hb_q, hb_d;
  logic        tx_en_q, rx_en_q, rst_q, busy_q, done_q;
  logic        tx_en_d, rx_en_d, rst_d, busy_d, done_d;
  logic        finish_s;
  logic [32:0] sum_s;
  logic [31:0] sat_s;

  // Saturating accumulate of the per-cycle error count (zero-extended).
  always_comb begin
    sum_s = {1'b0, err_q} + 33'(rx_error_count);
    if (sum_s[32]) begin
      sat_s = 32'hFFFF_FFFF;
    end else begin
      sat_s = sum_s[31:0];
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    window_d = window_q;
    thr_d    = thr_q;
    tout_d   = tout_q;
    err_d    = err_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    hb_d     = hb_q;
    finish_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          window_d = cfg_window_len;
          thr_d    = cfg_err_threshold;
          tout_d   = cfg_lock_timeout;
          err_d    = 32'd0;
          pass_d   = 1'b0;
          fail_d   = FC_NONE;
          hb_d     = 1'b0;
          cnt_d    = 32'd0;
          state_d  = S_ENABLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENABLE: begin
        cnt_d   = 32'd0;
        state_d = S_RX_RESET;
      end
      S_RX_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = 32'd0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over timeout, so a zero timeout still proceeds when lock
        // is already present.
        if (rx_block_lock) begin
          cnt_d   = 32'd0;
          state_d = S_SETTLE;
        end else if (cnt_q == {16'd0, tout_q}) begin
          fail_d   = FC_TIMEOUT;
          finish_s = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SETTLE: begin
        if (!rx_block_lock) begin
          fail_d   = FC_LOCKLOST;
          finish_s = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = 32'd0;
          if (window_q == 32'd0) begin
            finish_s = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_MEASURE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        if (rx_high_ber) begin
          hb_d = 1'b1;
        end else begin
          hb_d = hb_q;
        end
        // A cycle without lock ends the test and its sample is not counted.
        if (!rx_block_lock) begin
          fail_d   = FC_LOCKLOST;
          finish_s = 1'b1;
          state_d  = S_DONE;
        end else begin
          err_d = sat_s;
          if (cnt_q == window_q - 32'd1) begin
            finish_s = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The verdict is formed on entry to DONE so pass is valid with done,
    // using the total that includes the final sample.
    if (finish_s && (fail_d == FC_NONE)) begin
      if (err_d <= thr_q) begin
        pass_d = 1'b1;
      end else begin
        pass_d = 1'b0;
        fail_d = FC_THRESH;
      end
    end else begin
      pass_d = pass_d;
    end

    // Abort overrides every transition; the current total and code are kept.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 32'd0;
      pass_d  = 1'b0;
      err_d   = err_q;
      fail_d  = fail_q;
      hb_d    = hb_q;
    end else begin
      state_d = state_d;
    end
  end

  // Registered output decode from the next state.
  always_comb begin
    tx_en_d = (state_d == S_ENABLE)   || (state_d == S_RX_RESET) ||
              (state_d == S_WAIT_LOCK) || (state_d == S_SETTLE)  ||
              (state_d == S_MEASURE);
    rx_en_d = (state_d == S_RX_RESET) || (state_d == S_WAIT_LOCK) ||
              (state_d == S_SETTLE)   || (state_d == S_MEASURE);
    rst_d   = (state_d == S_RX_RESET);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, configuration, result and output registers.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      window_q <= 32'd0;
      thr_q    <= 32'd0;
      tout_q   <= 16'd0;
      err_q    <= 32'd0;
      pass_q   <= 1'b0;
      fail_q   <= 2'd0;
      hb_q     <= 1'b0;
      tx_en_q  <= 1'b0;
      rx_en_q  <= 1'b0;
      rst_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      window_q <= window_d;
      thr_q    <= thr_d;
      tout_q   <= tout_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      hb_q     <= hb_d;
      tx_en_q  <= tx_en_d;
      rx_en_q  <= rx_en_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cfg_tx_prbs31_enable = tx_en_q;
  assign cfg_rx_prbs31_enable = rx_en_q;
  assign phy_rx_rst           = rst_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pass                 = pass_q;
  assign fail_code            = fail_q;
  assign high_ber_seen        = hb_q;
  assign err_total            = err_q;

endmodule
